// File: rtl/per_demux_pkg.sv
// Shared constants for the outstanding-tracking request demultiplexer.
// The error word is kept wide so any DATA_WIDTH can slice its own copy.
package per_demux_pkg;

   localparam logic OPC_OK  = 1'b0;
   localparam logic OPC_ERR = 1'b1;

   localparam logic [1023:0] ERR_RDATA = {32{32'hBADACCE5}};

endpackage

// File: rtl/per_demux_err_slave.sv
// Error responder for unmapped addresses: answers every accepted request
// exactly one cycle later with an error opcode and the error word.
module per_demux_err_slave
   import per_demux_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  i_valid,
   output logic                  o_r_valid,
   output logic                  o_r_opc,
   output logic [DATA_WIDTH-1:0] o_r_rdata
);

   logic r_valid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_valid;
      end
   end

   assign o_r_valid = r_valid;
   assign o_r_opc   = r_valid ? OPC_ERR : OPC_OK;
   assign o_r_rdata = r_valid ? ERR_RDATA[DATA_WIDTH-1:0] : '0;

endmodule

// File: rtl/per_demux_ot.sv
// One-to-many request demultiplexer with in-order response tracking:
// requests only switch target once every outstanding response has returned.
module per_demux_ot
   import per_demux_pkg::*;
#(
   parameter int NB_MASTERS      = 2,
   parameter int ADDR_OFFSET     = 10,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     slave_req_i,
   input  logic [31:0]                              slave_add_i,
   input  logic                                     slave_wen_i,
   input  logic [DATA_WIDTH-1:0]                    slave_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]                  slave_be_i,
   output logic                                     slave_gnt_o,
   output logic                                     slave_r_valid_o,
   output logic                                     slave_r_opc_o,
   output logic [DATA_WIDTH-1:0]                    slave_r_rdata_o,
   output logic [NB_MASTERS-1:0]                    master_req_o,
   output logic [NB_MASTERS-1:0][31:0]              master_add_o,
   output logic [NB_MASTERS-1:0]                    master_wen_o,
   output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]    master_wdata_o,
   output logic [NB_MASTERS-1:0][DATA_WIDTH/8-1:0]  master_be_o,
   input  logic [NB_MASTERS-1:0]                    master_gnt_i,
   input  logic [NB_MASTERS-1:0]                    master_r_valid_i,
   input  logic [NB_MASTERS-1:0]                    master_r_opc_i,
   input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]    master_r_rdata_i
);

   localparam int SEL_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [SEL_W:0]   ERR_TGT = (SEL_W+1)'(NB_MASTERS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [SEL_W:0]          r_cur;
   logic [CNT_W-1:0]        r_cnt;

   logic [SEL_W-1:0]        w_sel;
   logic                    w_mapped;
   logic [SEL_W:0]          w_target;
   logic                    w_dn_gnt;
   logic                    w_rsp_valid;
   logic                    w_rsp_opc;
   logic [DATA_WIDTH-1:0]   w_rsp_rdata;
   logic                    w_rsp;
   logic                    w_accept;
   logic                    w_gnt;
   logic                    w_err_valid;
   logic                    w_err_opc;
   logic [DATA_WIDTH-1:0]   w_err_rdata;

   assign w_sel    = slave_add_i[ADDR_OFFSET +: SEL_W];
   assign w_mapped = ({1'b0, w_sel} < ERR_TGT);
   assign w_target = w_mapped ? {1'b0, w_sel} : ERR_TGT;

   always_comb begin
      w_dn_gnt    = 1'b0;
      w_rsp_valid = 1'b0;
      w_rsp_opc   = 1'b0;
      w_rsp_rdata = '0;
      for (int i = 0; i < NB_MASTERS; i++) begin
         if (w_sel == SEL_W'(i)) begin
            w_dn_gnt = master_gnt_i[i];
         end
         if (r_cur == (SEL_W+1)'(i)) begin
            w_rsp_valid = master_r_valid_i[i];
            w_rsp_opc   = master_r_opc_i[i];
            w_rsp_rdata = master_r_rdata_i[i];
         end
      end
      if (r_cur == ERR_TGT) begin
         w_rsp_valid = w_err_valid;
         w_rsp_opc   = w_err_opc;
         w_rsp_rdata = w_err_rdata;
      end
   end

   // A returning response frees a slot in the same cycle, so a full window can still accept.
   assign w_rsp    = w_rsp_valid & (r_cnt != '0);
   assign w_accept = slave_req_i & ((r_cnt == '0) | (w_target == r_cur))
                   & ((r_cnt < CNT_MAX) | w_rsp);
   assign w_gnt    = w_accept & (w_mapped ? w_dn_gnt : 1'b1);

   for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_port
      assign master_req_o[gi]   = rst_ni & w_accept & w_mapped & (w_sel == SEL_W'(gi));
      assign master_add_o[gi]   = slave_add_i;
      assign master_wen_o[gi]   = slave_wen_i;
      assign master_wdata_o[gi] = slave_wdata_i;
      assign master_be_o[gi]    = slave_be_i;
   end

   assign slave_gnt_o     = rst_ni & w_gnt;
   assign slave_r_valid_o = rst_ni & w_rsp;
   assign slave_r_opc_o   = rst_ni & w_rsp_opc;
   assign slave_r_rdata_o = rst_ni ? w_rsp_rdata : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cur <= '0;
         r_cnt <= '0;
      end else begin
         if (w_gnt) begin
            r_cur <= w_target;
         end
         case ({w_gnt, w_rsp})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   per_demux_err_slave #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_err_slave (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_valid    (w_gnt & ~w_mapped),
      .o_r_valid  (w_err_valid),
      .o_r_opc    (w_err_opc),
      .o_r_rdata  (w_err_rdata)
   );

endmodule

// File: tb/tb_per_demux_ot.sv
// Scenario bench for per_demux_ot with three downstream ports and one unmapped index.
// A rule-level model predicts grant, request routing and response forwarding each cycle.
module tb_per_demux_ot;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req;
   logic [31:0]       add;
   logic              wen;
   logic [31:0]       wdata;
   logic [3:0]        be;
   logic              gnt_o, rv_o, opc_o;
   logic [31:0]       rdata_o;
   logic [2:0]        mreq;
   logic [2:0][31:0]  madd;
   logic [2:0]        mwen;
   logic [2:0][31:0]  mwdata;
   logic [2:0][3:0]   mbe;
   logic [2:0]        m_gnt, m_rv, m_opc;
   logic [2:0][31:0]  m_rdata;

   int errors = 0;
   int checks = 0;

   // model state and per-cycle expectations
   int          md_cnt, md_cur, nx_cnt, nx_cur;
   bit          md_err, nx_err;
   bit          e_gnt, e_rv, e_opc;
   logic [2:0]  e_req;
   logic [31:0] e_rdata;

   always #5 clk = ~clk;

   per_demux_ot #(
      .NB_MASTERS      (3),
      .ADDR_OFFSET     (10),
      .DATA_WIDTH      (32),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .slave_req_i      (req),
      .slave_add_i      (add),
      .slave_wen_i      (wen),
      .slave_wdata_i    (wdata),
      .slave_be_i       (be),
      .slave_gnt_o      (gnt_o),
      .slave_r_valid_o  (rv_o),
      .slave_r_opc_o    (opc_o),
      .slave_r_rdata_o  (rdata_o),
      .master_req_o     (mreq),
      .master_add_o     (madd),
      .master_wen_o     (mwen),
      .master_wdata_o   (mwdata),
      .master_be_o      (mbe),
      .master_gnt_i     (m_gnt),
      .master_r_valid_i (m_rv),
      .master_r_opc_i   (m_opc),
      .master_r_rdata_i (m_rdata)
   );

   task automatic model_reset();
      md_cnt = 0;
      md_cur = 0;
      md_err = 1'b0;
   endtask

   // Drive one cycle of stimulus, predict outputs, and move to the sample point.
   task automatic apply(input bit rq, input int tgt, input logic [2:0] g, input logic [2:0] rv);
      bit mapped, rsp, acc;
      req = rq;
      add = $urandom;
      add[11:10] = tgt[1:0];
      wen = 1'($urandom);
      wdata = $urandom;
      be = 4'($urandom);
      m_gnt = g;
      m_rv = rv;
      m_opc = 3'($urandom);
      for (int i = 0; i < 3; i++) m_rdata[i] = $urandom;
      mapped  = (tgt < 3);
      rsp     = (md_cnt > 0) && ((md_cur < 3) ? rv[md_cur] : md_err);
      e_rv    = rsp;
      e_opc   = (md_cur < 3) ? m_opc[md_cur] : 1'b1;
      e_rdata = (md_cur < 3) ? m_rdata[md_cur] : 32'hBADACCE5;
      acc     = rq && (md_cnt == 0 || tgt == md_cur) && (md_cnt < 4 || rsp);
      e_req   = (acc && mapped) ? (3'b001 << tgt) : 3'b000;
      e_gnt   = acc && (mapped ? g[tgt] : 1'b1);
      nx_cnt  = md_cnt + (e_gnt ? 1 : 0) - (rsp ? 1 : 0);
      nx_cur  = e_gnt ? tgt : md_cur;
      nx_err  = e_gnt && !mapped;
      @(negedge clk);
   endtask

   task automatic commit();
      if (e_gnt) $display("txn target=%0d outstanding=%0d", nx_cur, nx_cnt);
      @(posedge clk);
      #1;
      md_cnt = nx_cnt;
      md_cur = nx_cur;
      md_err = nx_err;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 1'b1; add = 32'h0000_0400; wen = 1'b1; wdata = $urandom; be = 4'hF;
      m_gnt = 3'b111; m_rv = 3'b111; m_opc = 3'b111;
      for (int i = 0; i < 3; i++) m_rdata[i] = $urandom;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({gnt_o, mreq, rv_o, opc_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got gnt=%b req=%b rv=%b opc=%b exp all 0", gnt_o, mreq, rv_o, opc_o);
      end
      checks++;
      if (rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got=%h exp=0", rdata_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 6; c++) begin
         apply(c < 4, 1, 3'b111, (c >= 2) ? 3'b010 : 3'b000);
         checks++;
         if ({gnt_o, mreq, rv_o} !== {e_gnt, e_req, e_rv} || (c < 4 && gnt_o !== 1'b1)
             || rv_o !== (c >= 2)) begin
            errors++;
            $display("FAIL b2b_ctrl c=%0d got gnt=%b req=%b rv=%b exp gnt=%b req=%b rv=%b",
                     c, gnt_o, mreq, rv_o, e_gnt, e_req, e_rv);
         end
         if (e_rv) begin
            checks++;
            if ({opc_o, rdata_o} !== {e_opc, e_rdata}) begin
               errors++;
               $display("FAIL b2b_data c=%0d got opc=%b data=%h exp opc=%b data=%h",
                        c, opc_o, rdata_o, e_opc, e_rdata);
            end
         end
         commit();
      end
   endtask

   task automatic test_outstanding_limit();
      bit want_gnt, want_rv;
      for (int c = 0; c < 12; c++) begin
         apply(c <= 6, 0, 3'b111, (c >= 6) ? 3'b001 : 3'b000);
         want_gnt = (c < 4) || (c == 6);
         want_rv  = (c >= 6) && (c <= 10);
         checks++;
         if ({gnt_o, mreq, rv_o} !== {e_gnt, e_req, e_rv} || gnt_o !== want_gnt || rv_o !== want_rv) begin
            errors++;
            $display("FAIL limit_ctrl c=%0d got gnt=%b req=%b rv=%b exp gnt=%b req=%b rv=%b",
                     c, gnt_o, mreq, rv_o, want_gnt, e_req, want_rv);
         end
         if (e_rv) begin
            checks++;
            if (rdata_o !== e_rdata) begin
               errors++;
               $display("FAIL limit_data c=%0d got=%h exp=%h", c, rdata_o, e_rdata);
            end
         end
         commit();
      end
   endtask

   task automatic test_target_switch();
      bit want_gnt;
      for (int c = 0; c < 6; c++) begin
         apply(c < 5, (c == 0) ? 0 : 1, 3'b111, (c == 3) ? 3'b001 : ((c == 5) ? 3'b010 : 3'b000));
         want_gnt = (c == 0) || (c == 4);
         checks++;
         if ({gnt_o, mreq, rv_o} !== {e_gnt, e_req, e_rv} || gnt_o !== want_gnt
             || (c >= 1 && c <= 3 && mreq !== 3'b000)) begin
            errors++;
            $display("FAIL switch_ctrl c=%0d got gnt=%b req=%b rv=%b exp gnt=%b req=%b rv=%b",
                     c, gnt_o, mreq, rv_o, want_gnt, e_req, e_rv);
         end
         if (e_rv) begin
            checks++;
            if (rdata_o !== e_rdata) begin
               errors++;
               $display("FAIL switch_data c=%0d got=%h exp=%h", c, rdata_o, e_rdata);
            end
         end
         commit();
      end
   endtask

   task automatic test_unmapped();
      for (int c = 0; c < 3; c++) begin
         apply(c == 0, 3, 3'b000, 3'b111);
         checks++;
         if ({gnt_o, mreq, rv_o} !== {e_gnt, e_req, e_rv} || gnt_o !== (c == 0) || mreq !== 3'b000
             || rv_o !== (c == 1)) begin
            errors++;
            $display("FAIL unmapped_ctrl c=%0d got gnt=%b req=%b rv=%b exp gnt=%b req=000 rv=%b",
                     c, gnt_o, mreq, rv_o, (c == 0), (c == 1));
         end
         if (c == 1) begin
            checks++;
            if ({opc_o, rdata_o} !== {1'b1, 32'hBADACCE5}) begin
               errors++;
               $display("FAIL unmapped_data got opc=%b data=%h exp opc=1 data=badacce5", opc_o, rdata_o);
            end
         end
         commit();
      end
   endtask

   task automatic test_stray();
      logic [2:0] rv_tab [4] = '{3'b000, 3'b010, 3'b001, 3'b001};
      for (int c = 0; c < 4; c++) begin
         apply(c == 0, 0, 3'b111, rv_tab[c]);
         checks++;
         if ({gnt_o, mreq, rv_o} !== {e_gnt, e_req, e_rv} || rv_o !== (c == 2)) begin
            errors++;
            $display("FAIL stray_ctrl c=%0d got gnt=%b req=%b rv=%b exp gnt=%b req=%b rv=%b",
                     c, gnt_o, mreq, rv_o, e_gnt, e_req, (c == 2));
         end
         commit();
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         apply(1'b1, 2, 3'b111, 3'b000);
         checks++;
         if (gnt_o !== 1'b1 || mreq !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_fill c=%0d got gnt=%b req=%b exp gnt=1 req=100", c, gnt_o, mreq);
         end
         commit();
      end
      rst_n = 1'b0;
      m_rv = 3'b111;
      req = 1'b1;
      @(negedge clk);
      checks++;
      if ({gnt_o, mreq, rv_o, opc_o} !== 6'b0 || rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_hold got gnt=%b req=%b rv=%b opc=%b data=%h exp all 0",
                  gnt_o, mreq, rv_o, opc_o, rdata_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      apply(1'b0, 0, 3'b111, 3'b100);
      checks++;
      if (rv_o !== 1'b0 || rv_o !== e_rv) begin
         errors++;
         $display("FAIL rstmid_stray got rv=%b exp rv=0", rv_o);
      end
      commit();
      apply(1'b1, 1, 3'b111, 3'b000);
      checks++;
      if (gnt_o !== 1'b1 || mreq !== 3'b010) begin
         errors++;
         $display("FAIL rstmid_after got gnt=%b req=%b exp gnt=1 req=010", gnt_o, mreq);
      end
      commit();
   endtask

   task automatic test_random();
      int n_bad = 0;
      for (int c = 0; c < 400; c++) begin
         apply(($urandom % 4) != 0, int'($urandom % 4), 3'($urandom), 3'($urandom));
         checks++;
         if ({gnt_o, mreq, rv_o} !== {e_gnt, e_req, e_rv}) begin
            errors++;
            $display("FAIL rand_ctrl c=%0d got gnt=%b req=%b rv=%b exp gnt=%b req=%b rv=%b",
                     c, gnt_o, mreq, rv_o, e_gnt, e_req, e_rv);
         end
         if (e_rv) begin
            checks++;
            if ({opc_o, rdata_o} !== {e_opc, e_rdata}) begin
               errors++;
               $display("FAIL rand_data c=%0d got opc=%b data=%h exp opc=%b data=%h",
                        c, opc_o, rdata_o, e_opc, e_rdata);
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (madd[i] !== add || mwen[i] !== wen || mwdata[i] !== wdata || mbe[i] !== be) n_bad++;
         end
         commit();
      end
      checks++;
      if (n_bad !== 0) begin
         errors++;
         $display("FAIL rand_copy got %0d mismatching port copies exp 0", n_bad);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_back_to_back();
      test_outstanding_limit();
      test_target_switch();
      test_unmapped();
      test_stray();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
